// File: rtl/cpu_sequencer_pkg.sv
// Shared types and encodings for the simple-CPU sequencer: state enum,
// instruction fields, datapath select codes and the per-state output decode.
package cpu_pkg;

    typedef enum logic [4:0] {
        S_RST,
        S_IF1,
        S_IF_WAIT,
        S_IF2,
        S_UPC,
        S_WAIT_S,
        S_DECODE,
        S_WR_IMM,
        S_RD_RN,
        S_RD_RM,
        S_EXEC,
        S_WR_RD,
        S_CMP_S,
        S_ADDR,
        S_LD_ADDR,
        S_MEM_RD,
        S_WR_MEM,
        S_RD_RD,
        S_PASS,
        S_MEM_WR,
        S_HALT,
        S_ILLEGAL
    } state_e;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MEM     = 2'b00;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;

    localparam logic [1:0] VSEL_MDATA  = 2'b00;
    localparam logic [1:0] VSEL_SXIMM8 = 2'b01;
    localparam logic [1:0] VSEL_PC     = 2'b10;
    localparam logic [1:0] VSEL_C      = 2'b11;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       load_addr;
        logic       addr_sel;
        logic [1:0] mem_cmd;
        logic       illegal;
        logic       halted;
    } ctrl_t;

    // a_zero selects the zero A-input in EXEC for the single-operand ops.
    function automatic ctrl_t ctrl_for(state_e st, logic a_zero);
        ctrl_t c;
        c = '0;
        case (st)
            S_RST: begin
                c.reset_pc = 1'b1;
                c.load_pc  = 1'b1;
            end
            S_IF1, S_IF_WAIT: begin
                c.addr_sel = 1'b1;
                c.mem_cmd  = MEM_READ;
            end
            S_IF2: begin
                c.addr_sel = 1'b1;
                c.mem_cmd  = MEM_READ;
                c.load_ir  = 1'b1;
            end
            S_UPC:    c.load_pc = 1'b1;
            S_WAIT_S: c.w = 1'b1;
            S_WR_IMM: begin
                c.nsel  = NSEL_RN;
                c.vsel  = VSEL_SXIMM8;
                c.write = 1'b1;
            end
            S_RD_RN: begin
                c.nsel  = NSEL_RN;
                c.loada = 1'b1;
            end
            S_RD_RM: begin
                c.nsel  = NSEL_RM;
                c.loadb = 1'b1;
            end
            S_EXEC: begin
                c.loadc = 1'b1;
                c.asel  = a_zero;
            end
            S_WR_RD: begin
                c.nsel  = NSEL_RD;
                c.vsel  = VSEL_C;
                c.write = 1'b1;
            end
            S_CMP_S: c.loads = 1'b1;
            S_ADDR: begin
                c.bsel  = 1'b1;
                c.loadc = 1'b1;
            end
            S_LD_ADDR: c.load_addr = 1'b1;
            S_MEM_RD:  c.mem_cmd = MEM_READ;
            S_WR_MEM: begin
                c.mem_cmd = MEM_READ;
                c.nsel    = NSEL_RD;
                c.vsel    = VSEL_MDATA;
                c.write   = 1'b1;
            end
            S_RD_RD: begin
                c.nsel  = NSEL_RD;
                c.loadb = 1'b1;
            end
            S_PASS: begin
                c.asel  = 1'b1;
                c.loadc = 1'b1;
            end
            S_MEM_WR: c.mem_cmd = MEM_WRITE;
            S_HALT: begin
                c.halted = 1'b1;
                c.w      = 1'b1;
            end
            S_ILLEGAL: c.illegal = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control bundle between the sequencer (master) and the IR decoder/datapath (slave).
interface cpu_sequencer_if;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       load_addr;
    logic       addr_sel;
    logic [1:0] mem_cmd;
    logic       illegal;
    logic       halted;

    modport master (
        input  s, opcode, op,
        output w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
               load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd,
               illegal, halted
    );

    modport slave (
        output s, opcode, op,
        input  w, nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
               load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_cmd,
               illegal, halted
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle Moore sequencer: fetch, PC update, optional single-step pause,
// then per-instruction execute sequences for MOV/ALU/LDR/STR/HALT.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_RD_LAT = 1,
    parameter bit          STEP_MODE  = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    cpu_sequencer_if.master bus
);

    localparam logic [1:0] IF_WAIT_INIT = 2'((MEM_RD_LAT > 1) ? (MEM_RD_LAT - 2) : 0);
    localparam logic [1:0] MEM_RD_INIT  = 2'(MEM_RD_LAT - 1);

    state_e     st_q, st_d;
    logic [1:0] cnt_q, cnt_d;
    ctrl_t      ctrl_q;

    logic is_ldst, is_ldr, is_cmp, a_zero;

    assign is_ldr  = (bus.opcode == OPC_LDR);
    assign is_ldst = is_ldr || (bus.opcode == OPC_STR);
    assign is_cmp  = (bus.opcode == OPC_ALU) && (bus.op == OP_CMP);
    assign a_zero  = ((bus.opcode == OPC_MOV) && (bus.op == OP_MOV_REG)) ||
                     ((bus.opcode == OPC_ALU) && (bus.op == OP_MVN));

    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        case (st_q)
            S_RST: st_d = S_IF1;
            S_IF1: begin
                if (MEM_RD_LAT > 1) begin
                    st_d  = S_IF_WAIT;
                    cnt_d = IF_WAIT_INIT;
                end else begin
                    st_d = S_IF2;
                end
            end
            S_IF_WAIT: begin
                if (cnt_q == '0) st_d = S_IF2;
                else             cnt_d = cnt_q - 2'd1;
            end
            S_IF2:    st_d = S_UPC;
            S_UPC:    st_d = STEP_MODE ? S_WAIT_S : S_DECODE;
            S_WAIT_S: if (bus.s) st_d = S_DECODE;
            S_DECODE: begin
                if (bus.opcode == OPC_HALT) begin
                    st_d = S_HALT;
                end else begin
                    case ({bus.opcode, bus.op})
                        {OPC_MOV, OP_MOV_IMM}:                    st_d = S_WR_IMM;
                        {OPC_MOV, OP_MOV_REG}, {OPC_ALU, OP_MVN}: st_d = S_RD_RM;
                        {OPC_ALU, OP_ADD}, {OPC_ALU, OP_CMP}, {OPC_ALU, OP_AND},
                        {OPC_LDR, OP_MEM}, {OPC_STR, OP_MEM}:     st_d = S_RD_RN;
                        default:                                  st_d = S_ILLEGAL;
                    endcase
                end
            end
            S_RD_RN:   st_d = is_ldst ? S_ADDR : S_RD_RM;
            S_RD_RM:   st_d = is_cmp ? S_CMP_S : S_EXEC;
            S_EXEC:    st_d = S_WR_RD;
            S_ADDR:    st_d = S_LD_ADDR;
            S_LD_ADDR: begin
                if (is_ldr) begin
                    st_d  = S_MEM_RD;
                    cnt_d = MEM_RD_INIT;
                end else begin
                    st_d = S_RD_RD;
                end
            end
            S_MEM_RD: begin
                if (cnt_q == '0) st_d = S_WR_MEM;
                else             cnt_d = cnt_q - 2'd1;
            end
            S_RD_RD: st_d = S_PASS;
            S_PASS:  st_d = S_MEM_WR;
            S_HALT:  st_d = S_HALT;
            S_WR_IMM, S_WR_RD, S_CMP_S, S_WR_MEM, S_MEM_WR, S_ILLEGAL: st_d = S_IF1;
            default: st_d = S_IF1;
        endcase
    end

    // Outputs are registered from the next state so they always match st_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q   <= S_RST;
            cnt_q  <= '0;
            ctrl_q <= ctrl_for(S_RST, 1'b0);
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            ctrl_q <= ctrl_for(st_d, a_zero);
        end
    end

    assign bus.w         = ctrl_q.w;
    assign bus.nsel      = ctrl_q.nsel;
    assign bus.vsel      = ctrl_q.vsel;
    assign bus.write     = ctrl_q.write;
    assign bus.loada     = ctrl_q.loada;
    assign bus.loadb     = ctrl_q.loadb;
    assign bus.loadc     = ctrl_q.loadc;
    assign bus.loads     = ctrl_q.loads;
    assign bus.asel      = ctrl_q.asel;
    assign bus.bsel      = ctrl_q.bsel;
    assign bus.load_ir   = ctrl_q.load_ir;
    assign bus.load_pc   = ctrl_q.load_pc;
    assign bus.reset_pc  = ctrl_q.reset_pc;
    assign bus.load_addr = ctrl_q.load_addr;
    assign bus.addr_sel  = ctrl_q.addr_sel;
    assign bus.mem_cmd   = ctrl_q.mem_cmd;
    assign bus.illegal   = ctrl_q.illegal;
    assign bus.halted    = ctrl_q.halted;

endmodule
